fixed_dwn_groupsum: RTL and testbench

FIXED_DWN_GROUPSUM -- requirements
Module: fixed_dwn_groupsum

---
 rtl/fixed_dwn_groupsum.sv | 93 +++++++++
 tb/tb_fixed_dwn_groupsum.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_dwn_groupsum.sv
// Two-stage group popcount with optional argmax: S1 registers per-class counts, S2 the counts plus winner.
// Optional argmax comparator enabled by defining DWN_GROUPSUM_ARGMAX_EN; otherwise data_out_1 is tied to 0.
module fixed_dwn_groupsum #(
  parameter  int INPUT_SIZE  = 8,
  parameter  int NUM_CLASSES = 2,
  localparam int NC_SAFE     = (NUM_CLASSES < 1) ? 1 : NUM_CLASSES,
  localparam int GROUP_SIZE  = INPUT_SIZE / NC_SAFE,
  localparam int COUNT_WIDTH = $clog2(GROUP_SIZE + 1),
  localparam int IDX_WIDTH   = (NC_SAFE > 2) ? $clog2(NC_SAFE) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INPUT_SIZE-1:0]              data_in_0,
  input  logic                               data_in_0_valid,
  output logic                               data_in_0_ready,
  output logic [NUM_CLASSES*COUNT_WIDTH-1:0] data_out_0,
  output logic [IDX_WIDTH-1:0]               data_out_1,
  output logic                               data_out_0_valid,
  input  logic                               data_out_0_ready
);

  if (NUM_CLASSES < 1 || (INPUT_SIZE % NC_SAFE) != 0) begin : g_bad_cfg
    $error("fixed_dwn_groupsum: INPUT_SIZE must be a positive multiple of NUM_CLASSES");
  end

  logic                                         s1_valid;
  logic [NUM_CLASSES-1:0][COUNT_WIDTH-1:0]      s1_cnt;
  logic [NUM_CLASSES-1:0][COUNT_WIDTH-1:0]      cnt_d;
  logic                                         s1_adv;
  logic                                         s2_adv;

  // Ready depends only on stage occupancy and downstream ready, never on input valid.
  assign s2_adv          = !data_out_0_valid || data_out_0_ready;
  assign s1_adv          = !s1_valid || s2_adv;
  assign data_in_0_ready = s1_adv;

  always_comb begin
    cnt_d = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int b = 0; b < GROUP_SIZE; b++) begin
        cnt_d[c] = cnt_d[c] + COUNT_WIDTH'(data_in_0[c*GROUP_SIZE + b]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
    end else if (s1_adv) begin
      s1_valid <= data_in_0_valid;
      if (data_in_0_valid) s1_cnt <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_0_valid <= 1'b0;
      data_out_0       <= '0;
    end else if (s2_adv) begin
      data_out_0_valid <= s1_valid;
      if (s1_valid) data_out_0 <= s1_cnt;
    end
  end

`ifdef DWN_GROUPSUM_ARGMAX_EN
  logic [IDX_WIDTH-1:0]   arg_d;
  logic [COUNT_WIDTH-1:0] best_cnt;

  // Strict greater-than keeps the earliest class on ties.
  always_comb begin
    arg_d    = '0;
    best_cnt = s1_cnt[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (s1_cnt[c] > best_cnt) begin
        best_cnt = s1_cnt[c];
        arg_d    = IDX_WIDTH'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_1 <= '0;
    end else if (s2_adv && s1_valid) begin
      data_out_1 <= arg_d;
    end
  end
`else
  assign data_out_1 = '0;
`endif

endmodule

// File: tb/tb_fixed_dwn_groupsum.sv
// Bench for fixed_dwn_groupsum (INPUT_SIZE=8, NUM_CLASSES=2) with a queue scoreboard and $countones model.
// Expected argmax follows DWN_GROUPSUM_ARGMAX_EN: model value when defined, 0 otherwise.
module tb_fixed_dwn_groupsum;
  localparam int IN_W = 8;
  localparam int NC   = 2;
  localparam int GS   = 4;
  localparam int CW   = 3;
`ifdef DWN_GROUPSUM_ARGMAX_EN
  localparam bit ARGMAX_ON = 1'b1;
`else
  localparam bit ARGMAX_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [IN_W-1:0] data_in_0;
  logic            data_in_0_valid;
  logic            data_in_0_ready;
  logic [NC*CW-1:0] data_out_0;
  logic            data_out_1;
  logic            data_out_0_valid;
  logic            data_out_0_ready;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [6:0] exp_q[$];
  logic in_fire;
  logic out_fire;

  fixed_dwn_groupsum #(.INPUT_SIZE(IN_W), .NUM_CLASSES(NC)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_1       (data_out_1),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: group popcounts, then first class reaching the maximum.
  function automatic logic [6:0] model(input logic [7:0] d);
    int cnt[NC];
    int mx;
    int best;
    logic [5:0] pc;
    mx = 0;
    for (int c = 0; c < NC; c++) begin
      cnt[c] = $countones(d[c*GS +: GS]);
      if (cnt[c] > mx) mx = cnt[c];
    end
    best = -1;
    for (int c = 0; c < NC; c++) if (best < 0 && cnt[c] == mx) best = c;
    pc = '0;
    for (int c = 0; c < NC; c++) pc[c*CW +: CW] = CW'(cnt[c]);
    return {(ARGMAX_ON ? best[0] : 1'b0), pc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive, sample settled handshakes, check head of scoreboard, clock, update scoreboard.
  task automatic cycle(input logic vin, input logic [7:0] din, input logic rdy);
    data_in_0_valid  = vin;
    data_in_0        = din;
    data_out_0_ready = rdy;
    #1;
    in_fire  = vin && data_in_0_ready;
    out_fire = data_out_0_valid && rdy;
    if (data_out_0_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_out observed=%0h expected=no_beat", {data_out_1, data_out_0});
      end
      if (exp_q.size() != 0) chk("out_beat", {25'd0, data_out_1, data_out_0}, {25'd0, exp_q[0]});
    end
    @(posedge clk);
    if (out_fire && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_out++;
    end
    if (in_fire) exp_q.push_back(model(din));
    #1;
  endtask

  initial begin
    logic [7:0] b[3];
    logic [7:0] r;
    int n0;

    rst = 1'b0;
    data_in_0 = '0;
    data_in_0_valid = 1'b0;
    data_out_0_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(data_out_0_valid), 32'd0);
    chk("rst_out0", 32'(data_out_0), 32'd0);
    chk("rst_out1", 32'(data_out_1), 32'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(data_in_0_ready), 32'd1);

    // Basic count and latency
    data_in_0 = 8'b0111_0001; data_in_0_valid = 1'b1; data_out_0_ready = 1'b1;
    #1 chk("basic_in_ready", 32'(data_in_0_ready), 32'd1);
    @(posedge clk); #1;
    data_in_0_valid = 1'b0;
    chk("basic_not_yet", 32'(data_out_0_valid), 32'd0);
    @(posedge clk); #1;
    chk("basic_valid", 32'(data_out_0_valid), 32'd1);
    chk("basic_counts", 32'(data_out_0), 32'({3'd3, 3'd1}));
    chk("basic_argmax", 32'(data_out_1), ARGMAX_ON ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    chk("basic_drained", 32'(data_out_0_valid), 32'd0);

    // Tie and all-ones, back to back
    data_in_0 = 8'b0011_0101; data_in_0_valid = 1'b1;
    @(posedge clk); #1;
    data_in_0 = 8'hFF;
    @(posedge clk); #1;
    data_in_0_valid = 1'b0;
    chk("tie_valid", 32'(data_out_0_valid), 32'd1);
    chk("tie_counts", 32'(data_out_0), 32'({3'd2, 3'd2}));
    chk("tie_argmax", 32'(data_out_1), 32'd0);
    @(posedge clk); #1;
    chk("ff_valid", 32'(data_out_0_valid), 32'd1);
    chk("ff_counts", 32'(data_out_0), 32'({3'd4, 3'd4}));
    chk("ff_argmax", 32'(data_out_1), 32'd0);
    @(posedge clk); #1;
    chk("ff_drained", 32'(data_out_0_valid), 32'd0);

    // Backpressure: two accepted, third blocked, then drain in order
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    cycle(1'b1, b[0], 1'b0);
    chk("bp_acc0", 32'(in_fire), 32'd1);
    cycle(1'b1, b[1], 1'b0);
    chk("bp_acc1", 32'(in_fire), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, b[2], 1'b0);
      chk("bp_blocked", 32'(in_fire), 32'd0);
      chk("bp_in_ready", 32'(data_in_0_ready), 32'd0);
      chk("bp_hold_valid", 32'(data_out_0_valid), 32'd1);
    end
    n0 = n_out;
    cycle(1'b1, b[2], 1'b1);
    chk("bp_acc2", 32'(in_fire), 32'd1);
    chk("bp_out0", 32'(out_fire), 32'd1);
    cycle(1'b0, 8'd0, 1'b1);
    chk("bp_out1", 32'(out_fire), 32'd1);
    cycle(1'b0, 8'd0, 1'b1);
    chk("bp_out2", 32'(out_fire), 32'd1);
    chk("bp_count", 32'(n_out - n0), 32'd3);
    cycle(1'b0, 8'd0, 1'b1);
    chk("bp_empty", 32'(data_out_0_valid), 32'd0);

    // Streaming: 16 random beats, no bubbles
    n0 = n_out;
    for (int i = 0; i < 16; i++) begin
      r = 8'($urandom);
      cycle(1'b1, r, 1'b1);
      chk("str_accept", 32'(in_fire), 32'd1);
      if (i >= 2) chk("str_no_bubble", 32'(out_fire), 32'd1);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 8'd0, 1'b1);
      chk("str_drain", 32'(out_fire), 32'd1);
    end
    chk("str_count", 32'(n_out - n0), 32'd16);
    chk("str_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset with two beats in flight
    cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'($urandom), 1'b0);
    data_in_0_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(data_out_0_valid), 32'd0);
    chk("mid_rst_out0", 32'(data_out_0), 32'd0);
    chk("mid_rst_out1", 32'(data_out_1), 32'd0);
    exp_q.delete();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(data_in_0_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 8'd0, 1'b1);
      chk("post_rst_no_stale", 32'(out_fire), 32'd0);
    end
    n0 = n_out;
    cycle(1'b1, 8'($urandom), 1'b1);
    chk("post_rst_accept", 32'(in_fire), 32'd1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'd0, 1'b1);
    chk("post_rst_count", 32'(n_out - n0), 32'd1);
    chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
